fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the decode/register-file path.
- Owns the architectural fetch PC and issues word requests to instruction memory over a valid/ready request channel; memory returns in-order responses.
- Buffers returned instructions with their PCs in a small queue and presents them to decode over a valid/ready interface.
- Accepts a redirect (branch/jump target) that flushes queued and in-flight instructions.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_queue.sv | 65 ++++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential instruction address; wraps naturally at the top of the address space.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory request/response, redirect and decode handshake.
interface fetch_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush.
// A push is accepted on a full queue when a pop happens in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_reg [DEPTH];
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [DEPTH-1:0] slot_we;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
    assign slot_we[gi] = do_push && !flush && (wr_ptr_reg == AW'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_we[i]) mem_reg[i] <= push_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues imem requests and queues responses for decode.
// Build option FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int              QUEUE_DEPTH     = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);

  localparam int              OW         = $clog2(MAX_OUTSTANDING + 1);
  localparam int              CW         = $clog2(QUEUE_DEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
  // total counts every unanswered request; drop counts those already written off by a redirect
  logic [OW-1:0]   total_reg, total_next;
  logic [OW-1:0]   drop_reg, drop_next;
  logic [OW-1:0]   live_count;
  logic [XLEN-1:0] redirect_target;
  logic            req_valid, req_accept, rsp_keep, bypass_hit;
  logic            q_push, q_pop, q_full, q_empty;
  logic [CW-1:0]   q_count;
  fetch_entry_t    q_head, rsp_entry;

  assign live_count      = total_reg - drop_reg;
  assign redirect_target = bus.redirect_pc & ALIGN_MASK;
  assign req_accept      = req_valid && bus.imem_req_ready;
  assign rsp_keep        = bus.imem_rsp_valid && !bus.redirect_valid && (drop_reg == '0);
  assign rsp_entry       = '{pc: rsp_pc_reg, instr: bus.imem_rsp_data};

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = rsp_keep && q_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed entry consumed by decode this cycle never enters the queue.
  assign q_push = rsp_keep && !(bypass_hit && bus.dec_ready);
  assign q_pop  = !bus.redirect_valid && !q_empty && bus.dec_ready;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (q_push),
    .push_entry (rsp_entry),
    .pop        (q_pop),
    .flush      (bus.redirect_valid),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= BOOT;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    req_valid         = 1'b0;
    bus.imem_req_addr = reset ? RESET_PC : fetch_pc_reg;
    bus.dec_valid     = 1'b0;
    bus.dec_instr     = '0;
    bus.dec_pc        = '0;
    // In-flight live requests reserve queue slots so every kept response has room.
    if (!reset && state_reg == RUN && !bus.redirect_valid
        && (32'(live_count) + 32'(q_count) < QUEUE_DEPTH)
        && (32'(total_reg) < MAX_OUTSTANDING)) begin
      req_valid = 1'b1;
    end
    if (!reset) begin
      bus.dec_valid = !q_empty || bypass_hit;
      if (bypass_hit) begin
        bus.dec_instr = rsp_entry.instr;
        bus.dec_pc    = rsp_entry.pc;
      end else begin
        bus.dec_instr = q_head.instr;
        bus.dec_pc    = q_head.pc;
      end
    end
  end

  assign bus.imem_req_valid = req_valid;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    rsp_pc_next   = rsp_pc_reg;
    total_next    = total_reg + OW'(req_accept) - OW'(bus.imem_rsp_valid);
    drop_next     = drop_reg;
    if (bus.redirect_valid) begin
      fetch_pc_next = redirect_target;
      rsp_pc_next   = redirect_target;
      drop_next     = total_next;
    end else begin
      if (req_accept) fetch_pc_next = next_pc(fetch_pc_reg);
      if (bus.imem_rsp_valid && drop_reg != '0) drop_next = drop_reg - 1'b1;
      if (rsp_keep) rsp_pc_next = next_pc(rsp_pc_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      total_reg    <= '0;
      drop_reg     <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      rsp_pc_reg   <= rsp_pc_next;
      total_reg    <= total_next;
      drop_reg     <= drop_next;
    end
  end

  a_rsp_has_request: assert property (@(posedge clk) disable iff (reset)
    bus.imem_rsp_valid |-> (total_reg != '0));

  a_queue_no_overflow: assert property (@(posedge clk) disable iff (reset)
    q_push |-> (!q_full || q_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam int          QD     = 2;
  localparam int          MO     = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_if bus ();

  fetch_unit #(
    .RESET_PC        (RST_PC),
    .QUEUE_DEPTH     (QD),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks       = 0;
  int          errors       = 0;
  int          cyc          = 0;
  int          epoch        = 0;
  int          last_due     = -1;
  int          lat_min      = 1;
  int          lat_max      = 1;
  int          first_dv_cyc = -1;
  logic [31:0] exp_addr     = 32'h0;
  req_t        memq[$];
  logic [31:0] expq[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  bit          rsp_now;
  req_t        rsp_item;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, advance the model.
  task automatic step(input bit ready, input bit dready, input bit redir, input logic [31:0] rpc);
    bit          keep;
    bit          exp_dv;
    int          n_old;
    int          lat;
    req_t        r;
    logic [31:0] head_pc;
    bus.imem_req_ready = ready;
    bus.dec_ready      = dready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    rsp_now = 1'b0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      rsp_item = memq.pop_front();
      rsp_now  = 1'b1;
    end
    bus.imem_rsp_valid = rsp_now;
    bus.imem_rsp_data  = rsp_now ? mem_word(rsp_item.addr) : 32'h0;
    @(negedge clk);
    n_old = expq.size();
    keep  = rsp_now && !redir && (rsp_item.epoch == epoch);
    if (keep) expq.push_back(rsp_item.addr);
    exp_dv = (n_old > 0) || (BYPASS && keep);
    if (redir) check("req_valid_in_redirect", 32'(bus.imem_req_valid), 32'(0));
    if (bus.imem_req_valid) check("req_addr", bus.imem_req_addr, exp_addr);
    if (bus.imem_req_valid && ready) begin
      lat = $urandom_range(lat_max, lat_min);
      r.addr  = exp_addr;
      r.epoch = epoch;
      r.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = r.due;
      memq.push_back(r);
      acc_log.push_back(exp_addr);
      exp_addr = exp_addr + 32'd4;
    end
    check("outstanding_limit", 32'(memq.size() <= MO), 32'(1));
    check("dec_valid", 32'(bus.dec_valid), 32'(exp_dv));
    if (exp_dv) begin
      head_pc = expq[0];
      check("dec_pc", bus.dec_pc, head_pc);
      check("dec_instr", bus.dec_instr, mem_word(head_pc));
      if (dready && !redir) begin
        head_pc = expq.pop_front();
        pop_log.push_back(head_pc);
        $display("dec pc=%h instr=%h cyc=%0d", head_pc, bus.dec_instr, cyc);
      end
    end
    if (bus.dec_valid && first_dv_cyc < 0) first_dv_cyc = cyc;
    if (redir) begin
      expq.delete();
      epoch++;
      exp_addr = rpc & 32'hFFFF_FFFC;
    end
    check("queue_bound", 32'(expq.size() <= QD), 32'(1));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Resets the DUT and the memory model together, checking the reset-time outputs.
  task automatic do_reset();
    reset              = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.dec_ready      = 1'b0;
    memq.delete();
    expq.delete();
    acc_log.delete();
    pop_log.delete();
    epoch++;
    exp_addr     = RST_PC;
    last_due     = -1;
    first_dv_cyc = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'(0));
    check("rst_req_addr", bus.imem_req_addr, RST_PC);
    check("rst_dec_valid", 32'(bus.dec_valid), 32'(0));
    check("rst_dec_instr", bus.dec_instr, 32'h0);
    check("rst_dec_pc", bus.dec_pc, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    int          n;
    logic [31:0] held;
    logic [31:0] rpc;

    do_reset();

    // Streaming from reset with an always-ready, 1-cycle memory.
    lat_min = 1;
    lat_max = 1;
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("first_req0", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, 32'h0);
    check("first_req1", acc_log.size() > 1 ? acc_log[1] : 32'hDEAD_BEEF, 32'h4);
    check("first_req2", acc_log.size() > 2 ? acc_log[2] : 32'hDEAD_BEEF, 32'h8);
    check("first_dec_latency", 32'(first_dv_cyc), BYPASS ? 32'd2 : 32'd3);

    // Decode stall: queue fills, issue stops, then drains in order.
    step(1'b1, 1'b0, 1'b1, 32'h0);
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall_req_valid", 32'(bus.imem_req_valid), 32'(0));
    check("stall_dec_valid", 32'(bus.dec_valid), 32'(1));
    check("stall_queue_full", 32'(expq.size()), 32'(QD));
    pop_log.delete();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("drain0", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF, 32'h0);
    check("drain1", pop_log.size() > 1 ? pop_log[1] : 32'hDEAD_BEEF, 32'h4);

    // Redirect with two requests in flight.
    lat_min = 3;
    lat_max = 3;
    n = 0;
    while (memq.size() < 2 && n < 20) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    check("two_outstanding", 32'(memq.size()), 32'd2);
    pop_log.delete();
    step(1'b1, 1'b1, 1'b1, 32'h100);
    n = 0;
    while (pop_log.size() == 0 && n < 40) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    check("redirect_first_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);

    // Memory not ready: address and fetch PC hold.
    lat_min = 1;
    lat_max = 1;
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    held = exp_addr;
    repeat (5) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("addr_held", bus.imem_req_addr, held);
    end
    acc_log.delete();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("held_addr_accepted", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, held);

    // Misaligned redirect target and address wrap.
    acc_log.delete();
    step(1'b1, 1'b1, 1'b1, 32'h203);
    n = 0;
    while (acc_log.size() < 1 && n < 20) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    check("aligned_redirect", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, 32'h200);
    acc_log.delete();
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    n = 0;
    while (acc_log.size() < 2 && n < 20) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    check("wrap_top", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("wrap_zero", acc_log.size() > 1 ? acc_log[1] : 32'hDEAD_BEEF, 32'h0);

    // Random traffic: variable latency, backpressure on both sides, random redirects.
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 600; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, rpc);
    end

    // Reset in the middle of traffic, then restart cleanly.
    do_reset();
    lat_min = 1;
    lat_max = 1;
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("rereset_first_req", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, RST_PC);
    check("rereset_dec_latency", 32'(first_dv_cyc), BYPASS ? 32'd2 : 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
